// File: rtl/param_updown_counter_pkg.sv
// Shared constants for the prescaled up/down counter: direction encoding and
// boundary-mode selection.
package param_updown_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

endpackage

// File: rtl/param_updown_counter_step_prescaler.sv
// Prescaler: emits a step strobe on every DIV-th enabled cycle. It holds while
// en is low and clears on reset or on clear.
module step_prescaler
  import param_updown_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic step
);

  if (DIV < 1) begin : g_bad_div
    $error("step_prescaler: DIV must be >= 1");
  end

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign step    = en && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Prescaled up/down counter with a clamped parallel load, a wrap or saturate
// boundary mode, and a registered terminal-count pulse.
module param_updown_counter
  import param_updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = MODE_WRAP,
  parameter int DIV      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down_sw,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             tc
);

  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL out of range 1..2**WIDTH-1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("param_updown_counter: DIV must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             step;
  logic             is_top, is_bot;

  step_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (load),
    .step  (step)
  );

  assign is_top = (count_q == MAX_C);
  assign is_bot = (count_q == '0);

  // Load masks the step strobe; tc flags only steps taken at the boundary
  // in the direction of travel.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (data > MAX_C) ? MAX_C : data;
    end else if (step) begin
      if (up_down_sw == DIR_UP) begin
        if (is_top) begin
          tc_d    = 1'b1;
          count_d = (SATURATE == MODE_SAT) ? MAX_C : '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (is_bot) begin
          tc_d    = 1'b1;
          count_d = (SATURATE == MODE_SAT) ? '0 : MAX_C;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign at_max = is_top;
  assign at_min = is_bot;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: three counter configurations (wrap, saturate, DIV=3)
// share one stimulus stream and are checked against an arithmetic model.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up_down_sw = 1'b1;
  logic       load = 1'b0;
  logic [3:0] data = 4'd0;

  logic [3:0] cnt_w, cnt_s, cnt_d;
  logic       amax_w, amax_s, amax_d;
  logic       amin_w, amin_s, amin_d;
  logic       tc_w, tc_s, tc_d;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per instance: wrap, saturate, div3
  int P_MAX [3] = '{9, 9, 9};
  int P_SAT [3] = '{0, 1, 0};
  int P_DIV [3] = '{1, 1, 3};
  int m_cnt [3];
  int m_pre [3];
  int m_tc  [3];

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .DIV(1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .up_down_sw(up_down_sw), .load(load),
    .data(data), .count(cnt_w), .at_max(amax_w), .at_min(amin_w), .tc(tc_w));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .DIV(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up_down_sw(up_down_sw), .load(load),
    .data(data), .count(cnt_s), .at_max(amax_s), .at_min(amin_s), .tc(tc_s));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .DIV(3)) u_div (
    .clk(clk), .reset(reset), .en(en), .up_down_sw(up_down_sw), .load(load),
    .data(data), .count(cnt_d), .at_max(amax_d), .at_min(amin_d), .tc(tc_d));

  logic [3:0] act_cnt  [3];
  logic       act_tc   [3];
  logic       act_amax [3];
  logic       act_amin [3];
  assign act_cnt[0]  = cnt_w;  assign act_cnt[1]  = cnt_s;  assign act_cnt[2]  = cnt_d;
  assign act_tc[0]   = tc_w;   assign act_tc[1]   = tc_s;   assign act_tc[2]   = tc_d;
  assign act_amax[0] = amax_w; assign act_amax[1] = amax_s; assign act_amax[2] = amax_d;
  assign act_amin[0] = amin_w; assign act_amin[1] = amin_s; assign act_amin[2] = amin_d;

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(data) > P_MAX[k]) ? P_MAX[k] : int'(data);
        m_pre[k] = 0; m_tc[k] = 0;
      end else if (en) begin
        m_tc[k]  = 0;
        m_pre[k] = m_pre[k] + 1;
        if (m_pre[k] == P_DIV[k]) begin
          m_pre[k] = 0;
          if (up_down_sw) begin
            m_tc[k] = (m_cnt[k] == P_MAX[k]) ? 1 : 0;
            if (!(m_tc[k] == 1 && P_SAT[k] == 1))
              m_cnt[k] = (m_cnt[k] + 1) % (P_MAX[k] + 1);
          end else begin
            m_tc[k] = (m_cnt[k] == 0) ? 1 : 0;
            if (!(m_tc[k] == 1 && P_SAT[k] == 1))
              m_cnt[k] = (m_cnt[k] + P_MAX[k]) % (P_MAX[k] + 1);
          end
        end
      end else begin
        m_tc[k] = 0;
      end
    end
  endtask

  // One clock: model follows the inputs seen at the edge, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic u, input logic [3:0] d);
    reset = r; load = l; en = e; up_down_sw = u; data = d;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (act_cnt[k] !== 4'd0 || act_tc[k] !== 1'b0 || act_amin[k] !== 1'b1 || act_amax[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d: count=%0d tc=%b at_min=%b at_max=%b, required 0 0 1 0",
                 k, act_cnt[k], act_tc[k], act_amin[k], act_amax[k]);
      end
    end
  endtask

  task automatic test_wrap_up();
    drive(1, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_checks++;
      if (cnt_w !== 4'(i % 10) || tc_w !== (i == 10)) begin
        n_fail++;
        $display("FAIL wrap_up step%0d: count=%0d tc=%b, required %0d %b", i, cnt_w, tc_w, i % 10, (i == 10));
      end
    end
  endtask

  task automatic test_saturate_down();
    drive(0, 1, 0, 0, 4'd1); tick();
    n_checks++;
    if (cnt_s !== 4'd1 || tc_s !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_load: count=%0d tc=%b, required 1 0", cnt_s, tc_s);
    end
    drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (cnt_s !== 4'd0 || tc_s !== (i > 0) || amin_s !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_down step%0d: count=%0d tc=%b at_min=%b, required 0 %b 1", i, cnt_s, tc_s, amin_s, (i > 0));
      end
    end
  endtask

  task automatic test_down_wrap();
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    n_checks++;
    if (cnt_w !== 4'd9 || tc_w !== 1'b1 || amax_w !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: count=%0d tc=%b at_max=%b, required 9 1 1", cnt_w, tc_w, amax_w);
    end
    drive(0, 0, 0, 0, 0); tick();
    n_checks++;
    if (tc_w !== 1'b0 || tc_s !== 1'b0) begin
      n_fail++;
      $display("FAIL tc_one_cycle: tc_wrap=%b tc_sat=%b, required 0 0", tc_w, tc_s);
    end
  endtask

  task automatic test_load_clamp();
    drive(0, 1, 1, 1, 4'd13); tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (act_cnt[k] !== 4'd9 || act_amax[k] !== 1'b1 || act_tc[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL load_clamp inst%0d: count=%0d at_max=%b tc=%b, required 9 1 0", k, act_cnt[k], act_amax[k], act_tc[k]);
      end
    end
    drive(0, 1, 1, 1, 4'd4); tick();
    n_checks++;
    if (cnt_w !== 4'd4 || tc_w !== 1'b0) begin
      n_fail++;
      $display("FAIL load_wins: count=%0d tc=%b, required 4 0", cnt_w, tc_w);
    end
  endtask

  task automatic test_prescale();
    drive(1, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_checks++;
      if (cnt_d !== 4'(i / 3)) begin
        n_fail++;
        $display("FAIL prescale cyc%0d: count=%0d, required %0d", i, cnt_d, i / 3);
      end
    end
    drive(1, 0, 0, 1, 0); tick();
    drive(0, 0, 1, 1, 0);
    repeat (4) tick();
    drive(0, 0, 0, 1, 0);
    repeat (2) tick();
    drive(0, 0, 1, 1, 0);
    tick();
    n_checks++;
    if (cnt_d !== 4'd1) begin
      n_fail++;
      $display("FAIL prescale_hold: count=%0d, required 1", cnt_d);
    end
    tick();
    n_checks++;
    if (cnt_d !== 4'd2) begin
      n_fail++;
      $display("FAIL prescale_delay: count=%0d, required 2", cnt_d);
    end
  endtask

  task automatic test_reset_override();
    drive(0, 1, 0, 1, 4'd5); tick();
    drive(1, 1, 1, 1, 4'd7); tick();
    n_checks++;
    if (cnt_w !== 4'd0 || tc_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_override: count=%0d tc=%b, required 0 0", cnt_w, tc_w);
    end
    drive(0, 0, 1, 1, 0); tick();
    n_checks++;
    if (cnt_w !== 4'd1) begin
      n_fail++;
      $display("FAIL resume_after_reset: count=%0d, required 1", cnt_w);
    end
  endtask

  task automatic test_toggle();
    drive(1, 0, 0, 1, 0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, (i % 2 == 0), 0);
      tick();
      n_checks++;
      if (cnt_w !== 4'((i % 2 == 0) ? 1 : 0) || tc_w !== 1'b0) begin
        n_fail++;
        $display("FAIL toggle step%0d: count=%0d tc=%b, required %0d 0", i, cnt_w, tc_w, (i % 2 == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    drive(1, 0, 0, 1, 0); tick();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (act_cnt[k] !== 4'(m_cnt[k]) || act_tc[k] !== 1'(m_tc[k]) ||
            act_amax[k] !== (m_cnt[k] == P_MAX[k]) || act_amin[k] !== (m_cnt[k] == 0)) begin
          n_fail++;
          $display("FAIL random cyc%0d inst%0d: count=%0d tc=%b at_max=%b at_min=%b, required %0d %0d %b %b",
                   i, k, act_cnt[k], act_tc[k], act_amax[k], act_amin[k],
                   m_cnt[k], m_tc[k], (m_cnt[k] == P_MAX[k]), (m_cnt[k] == 0));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_wrap_up();
    test_saturate_down();
    test_down_wrap();
    test_load_clamp();
    test_prescale();
    test_reset_override();
    test_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
